hazard_ctrl: RTL and testbench

//  Pipeline sequencing controller for the 5-stage RV32I core. Detects load-use

---
 rtl/hazard_ctrl_if.sv | 49 ++++
 rtl/hazard_ctrl.sv | 149 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - pipeline hazard controller signal bundle
//
// Purpose: groups the pipeline-facing inputs and the sequencing/perf outputs
//          of hazard_ctrl. The slave modport is the controller and the master
//          modport is the pipeline (or testbench) that drives it.
// Signals:
//   id_rs1/id_rs2, id_use_rs1/id_use_rs2 : source registers of the ID instruction
//   ex_rd, ex_MemRead, ex_br_taken      : EX instruction destination, load flag, taken branch
//   dmem_req, dmem_ready                : MEM stage access request and completion
//   perf_clr                            : synchronous clear of perf counters
//   pc_hold, if_id_hold, if_id_flush,
//   id_ex_flush, pipe_hold, mem_err     : sequencing controls
//   stall_cnt, flush_cnt                : saturating perf counters
interface hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic [4:0]       ex_rd;
    logic             ex_MemRead;
    logic             ex_br_taken;
    logic             dmem_req;
    logic             dmem_ready;
    logic             perf_clr;
    logic             pc_hold;
    logic             if_id_hold;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             pipe_hold;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_MemRead,
               ex_br_taken, dmem_req, dmem_ready, perf_clr,
        input  pc_hold, if_id_hold, if_id_flush, id_ex_flush, pipe_hold,
               mem_err, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_MemRead,
               ex_br_taken, dmem_req, dmem_ready, perf_clr,
        output pc_hold, if_id_hold, if_id_flush, id_ex_flush, pipe_hold,
               mem_err, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - 5-stage RV32I pipeline hazard / sequencing controller
//
// Purpose: detects load-use hazards, taken-branch redirects and data-memory
//          wait states; drives PC hold, IF/ID hold/flush, ID/EX bubble and
//          global pipeline hold; keeps saturating stall/flush perf counters.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : hazard_ctrl_if.slave (pipeline inputs, control outputs, counters)
// Parameters:
//   LU_BUBBLES  : bubbles per load-use hazard (1..7)
//   MEM_TIMEOUT : max consecutive dmem wait cycles before mem_err (1..255)
//   CNT_W       : perf counter width
module hazard_ctrl #(
    parameter int LU_BUBBLES  = 1,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    hazard_ctrl_if.slave    bus
);
    typedef enum logic [1:0] {RUN, LU_STALL, MEM_WAIT} state_t;

    localparam logic [2:0] LU_RELOAD = 3'(LU_BUBBLES - 1);
    localparam logic [7:0] TIMEOUT   = 8'(MEM_TIMEOUT);

    state_t           r_state;
    state_t           r_saved;
    logic [2:0]       r_lu_cnt;
    logic [7:0]       r_wait_cnt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic             w_lu_hit;
    logic             w_wait;
    logic             w_timeout;
    logic             w_release;
    state_t           w_base;
    state_t           w_nxt_state;
    state_t           w_nxt_saved;
    logic [2:0]       w_nxt_lu;
    logic [7:0]       w_nxt_wait;
    logic             w_pc_hold;
    logic             w_if_id_hold;
    logic             w_if_id_flush;
    logic             w_id_ex_flush;
    logic             w_pipe_hold;
    logic             w_mem_err;

    // x0 is hard-wired zero, so a load targeting it never creates a dependency
    assign w_lu_hit = bus.ex_MemRead && (bus.ex_rd != 5'd0) &&
                      ((bus.id_use_rs1 && (bus.ex_rd == bus.id_rs1)) ||
                       (bus.id_use_rs2 && (bus.ex_rd == bus.id_rs2)));
    assign w_wait    = bus.dmem_req && !bus.dmem_ready;
    assign w_timeout = (r_state == MEM_WAIT) && !bus.dmem_ready && (r_wait_cnt == TIMEOUT);
    assign w_release = (r_state == MEM_WAIT) && (bus.dmem_ready || w_timeout);
    // While waiting, the state that would be in effect without the wait
    assign w_base    = (r_state == MEM_WAIT) ? r_saved : r_state;

    always_comb begin
        w_pc_hold     = 1'b0;
        w_if_id_hold  = 1'b0;
        w_if_id_flush = 1'b0;
        w_id_ex_flush = 1'b0;
        w_pipe_hold   = 1'b0;
        w_mem_err     = 1'b0;
        w_nxt_state   = r_state;
        w_nxt_saved   = r_saved;
        w_nxt_lu      = r_lu_cnt;
        w_nxt_wait    = r_wait_cnt;
        if ((r_state == MEM_WAIT) && !w_release) begin
            w_pipe_hold  = 1'b1;
            w_pc_hold    = 1'b1;
            w_if_id_hold = 1'b1;
            w_nxt_wait   = r_wait_cnt + 8'd1;
        end else begin
            // On a release cycle the wait is treated as gone (timeout abandons it)
            w_mem_err = w_timeout;
            if ((r_state != MEM_WAIT) && w_wait) begin
                w_pipe_hold  = 1'b1;
                w_pc_hold    = 1'b1;
                w_if_id_hold = 1'b1;
                w_nxt_state  = MEM_WAIT;
                w_nxt_saved  = w_base;
                w_nxt_wait   = 8'd1;
            end else if (w_base == LU_STALL) begin
                w_pc_hold     = 1'b1;
                w_if_id_hold  = 1'b1;
                w_id_ex_flush = 1'b1;
                if (r_lu_cnt <= 3'd1) begin
                    w_nxt_state = RUN;
                end else begin
                    w_nxt_state = LU_STALL;
                    w_nxt_lu    = r_lu_cnt - 3'd1;
                end
            end else if (bus.ex_br_taken) begin
                // Wrong-path load-use hits are discarded with the flush
                w_if_id_flush = 1'b1;
                w_id_ex_flush = 1'b1;
                w_nxt_state   = RUN;
            end else if (w_lu_hit) begin
                w_pc_hold     = 1'b1;
                w_if_id_hold  = 1'b1;
                w_id_ex_flush = 1'b1;
                w_nxt_state   = (LU_BUBBLES > 1) ? LU_STALL : RUN;
                w_nxt_lu      = LU_RELOAD;
            end else begin
                w_nxt_state = RUN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= RUN;
            r_saved     <= RUN;
            r_lu_cnt    <= 3'd0;
            r_wait_cnt  <= 8'd0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state    <= w_nxt_state;
            r_saved    <= w_nxt_saved;
            r_lu_cnt   <= w_nxt_lu;
            r_wait_cnt <= w_nxt_wait;
            if (bus.perf_clr) begin
                r_stall_cnt <= '0;
                r_flush_cnt <= '0;
            end else begin
                // A stall with a taken branch is the redirect, not lost work
                if (w_pc_hold && !bus.ex_br_taken && (r_stall_cnt != '1))
                    r_stall_cnt <= r_stall_cnt + 1'b1;
                if (w_if_id_flush && (r_flush_cnt != '1))
                    r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    // Outputs are forced low while reset is asserted, whatever the inputs do
    assign bus.pc_hold     = rst_n & w_pc_hold;
    assign bus.if_id_hold  = rst_n & w_if_id_hold;
    assign bus.if_id_flush = rst_n & w_if_id_flush;
    assign bus.id_ex_flush = rst_n & w_id_ex_flush;
    assign bus.pipe_hold   = rst_n & w_pipe_hold;
    assign bus.mem_err     = rst_n & w_mem_err;
    assign bus.stall_cnt   = r_stall_cnt;
    assign bus.flush_cnt   = r_flush_cnt;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed-vector bench for hazard_ctrl
module tb_hazard_ctrl;
    // Output vector order: {pipe_hold, pc_hold, if_id_hold, if_id_flush, id_ex_flush, mem_err}
    localparam logic [5:0] O_NONE = 6'b000000;
    localparam logic [5:0] O_HOLD = 6'b111000;
    localparam logic [5:0] O_LU   = 6'b011010;
    localparam logic [5:0] O_BR   = 6'b000110;
    localparam logic [5:0] O_ERR  = 6'b000001;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    hazard_ctrl_if #(.CNT_W(32)) ifa ();
    hazard_ctrl_if #(.CNT_W(4))  ifb ();

    assign ifb.id_rs1      = ifa.id_rs1;
    assign ifb.id_rs2      = ifa.id_rs2;
    assign ifb.id_use_rs1  = ifa.id_use_rs1;
    assign ifb.id_use_rs2  = ifa.id_use_rs2;
    assign ifb.ex_rd       = ifa.ex_rd;
    assign ifb.ex_MemRead  = ifa.ex_MemRead;
    assign ifb.ex_br_taken = ifa.ex_br_taken;
    assign ifb.dmem_req    = ifa.dmem_req;
    assign ifb.dmem_ready  = ifa.dmem_ready;
    assign ifb.perf_clr    = ifa.perf_clr;

    hazard_ctrl #(.LU_BUBBLES(1), .MEM_TIMEOUT(8), .CNT_W(32)) u_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa)
    );

    hazard_ctrl #(.LU_BUBBLES(3), .MEM_TIMEOUT(255), .CNT_W(4)) u_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb)
    );

    function automatic logic [5:0] outs_a();
        return {ifa.pipe_hold, ifa.pc_hold, ifa.if_id_hold, ifa.if_id_flush, ifa.id_ex_flush, ifa.mem_err};
    endfunction

    function automatic logic [5:0] outs_b();
        return {ifb.pipe_hold, ifb.pc_hold, ifb.if_id_hold, ifb.if_id_flush, ifb.id_ex_flush, ifb.mem_err};
    endfunction

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1, input logic u2,
                         input logic [4:0] rd, input logic mr, input logic br,
                         input logic req, input logic rdy, input logic clr);
        ifa.id_rs1      = rs1;
        ifa.id_rs2      = rs2;
        ifa.id_use_rs1  = u1;
        ifa.id_use_rs2  = u2;
        ifa.ex_rd       = rd;
        ifa.ex_MemRead  = mr;
        ifa.ex_br_taken = br;
        ifa.dmem_req    = req;
        ifa.dmem_ready  = rdy;
        ifa.perf_clr    = clr;
    endtask

    task automatic idle();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Load x5 in EX, add x6,x5,x1 in ID
    task automatic lu_vec();
        drive(5'd5, 5'd1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        lu_vec();
        #1;
        n_vec++; if (outs_a() !== O_NONE) begin $display("FAIL reset_outs_a got %b want %b", outs_a(), O_NONE); n_err++; end
        n_vec++; if (outs_b() !== O_NONE) begin $display("FAIL reset_outs_b got %b want %b", outs_b(), O_NONE); n_err++; end
        @(negedge clk);
        n_vec++; if (ifa.stall_cnt !== 32'd0) begin $display("FAIL reset_stall_a got %0d want 0", ifa.stall_cnt); n_err++; end
        n_vec++; if (ifa.flush_cnt !== 32'd0) begin $display("FAIL reset_flush_a got %0d want 0", ifa.flush_cnt); n_err++; end
        n_vec++; if (ifb.stall_cnt !== 4'd0) begin $display("FAIL reset_stall_b got %0d want 0", ifb.stall_cnt); n_err++; end
    endtask

    task automatic test_lu_single();
        do_reset();
        lu_vec(); #1;
        n_vec++; if (outs_a() !== O_LU) begin $display("FAIL lu1_hit got %b want %b", outs_a(), O_LU); n_err++; end
        @(negedge clk); idle(); #1;
        n_vec++; if (outs_a() !== O_NONE) begin $display("FAIL lu1_after got %b want %b", outs_a(), O_NONE); n_err++; end
        @(negedge clk);
        n_vec++; if (ifa.stall_cnt !== 32'd1) begin $display("FAIL lu1_stall_cnt got %0d want 1", ifa.stall_cnt); n_err++; end
        // Load into x0 matched against rs1=x0: no hazard
        drive(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); #1;
        n_vec++; if (outs_a() !== O_NONE) begin $display("FAIL lu_x0 got %b want %b", outs_a(), O_NONE); n_err++; end
        @(negedge clk);
        // rs1 matches but is not read
        drive(5'd5, 5'd1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); #1;
        n_vec++; if (outs_a() !== O_NONE) begin $display("FAIL lu_unused got %b want %b", outs_a(), O_NONE); n_err++; end
        @(negedge clk);
        // rs2 match
        drive(5'd1, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); #1;
        n_vec++; if (outs_a() !== O_LU) begin $display("FAIL lu_rs2 got %b want %b", outs_a(), O_LU); n_err++; end
        @(negedge clk); idle();
        n_vec++; if (ifa.stall_cnt !== 32'd2) begin $display("FAIL lu_rs2_stall_cnt got %0d want 2", ifa.stall_cnt); n_err++; end
    endtask

    task automatic test_lu_multi();
        logic [5:0] exp_b [4];
        exp_b = '{O_LU, O_LU, O_LU, O_NONE};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            if (i == 0) lu_vec(); else idle();
            #1;
            n_vec++; if (outs_b() !== exp_b[i]) begin $display("FAIL lu3_cycle%0d got %b want %b", i, outs_b(), exp_b[i]); n_err++; end
            @(negedge clk);
        end
        n_vec++; if (ifb.stall_cnt !== 4'd3) begin $display("FAIL lu3_stall_cnt got %0d want 3", ifb.stall_cnt); n_err++; end
    endtask

    task automatic test_branch_lu();
        do_reset();
        drive(5'd5, 5'd1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); #1;
        n_vec++; if (outs_a() !== O_BR) begin $display("FAIL br_lu_a got %b want %b", outs_a(), O_BR); n_err++; end
        n_vec++; if (outs_b() !== O_BR) begin $display("FAIL br_lu_b got %b want %b", outs_b(), O_BR); n_err++; end
        @(negedge clk); idle(); #1;
        n_vec++; if (outs_b() !== O_NONE) begin $display("FAIL br_lu_after_b got %b want %b", outs_b(), O_NONE); n_err++; end
        @(negedge clk);
        n_vec++; if (ifa.flush_cnt !== 32'd1) begin $display("FAIL br_flush_cnt got %0d want 1", ifa.flush_cnt); n_err++; end
        n_vec++; if (ifa.stall_cnt !== 32'd0) begin $display("FAIL br_stall_cnt got %0d want 0", ifa.stall_cnt); n_err++; end
    endtask

    task automatic test_mem_wait();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, (i == 4), 1'b0); #1;
            n_vec++;
            if (outs_a() !== ((i == 4) ? O_NONE : O_HOLD)) begin
                $display("FAIL wait_cycle%0d got %b want %b", i, outs_a(), (i == 4) ? O_NONE : O_HOLD); n_err++;
            end
            @(negedge clk);
        end
        idle();
        n_vec++; if (ifa.stall_cnt !== 32'd4) begin $display("FAIL wait_stall_cnt got %0d want 4", ifa.stall_cnt); n_err++; end
        n_vec++; if (ifa.flush_cnt !== 32'd0) begin $display("FAIL wait_flush_cnt got %0d want 0", ifa.flush_cnt); n_err++; end
    endtask

    task automatic test_wait_branch();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, (i == 2), 1'b0); #1;
            n_vec++;
            if (outs_a() !== ((i == 2) ? O_BR : O_HOLD)) begin
                $display("FAIL wait_br_cycle%0d got %b want %b", i, outs_a(), (i == 2) ? O_BR : O_HOLD); n_err++;
            end
            @(negedge clk);
        end
        idle();
        n_vec++; if (ifa.flush_cnt !== 32'd1) begin $display("FAIL wait_br_flush_cnt got %0d want 1", ifa.flush_cnt); n_err++; end
        n_vec++; if (ifa.stall_cnt !== 32'd0) begin $display("FAIL wait_br_stall_cnt got %0d want 0", ifa.stall_cnt); n_err++; end
    endtask

    task automatic test_timeout();
        do_reset();
        for (int i = 0; i < 9; i++) begin
            drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); #1;
            n_vec++;
            if (outs_a() !== ((i == 8) ? O_ERR : O_HOLD)) begin
                $display("FAIL timeout_cycle%0d got %b want %b", i, outs_a(), (i == 8) ? O_ERR : O_HOLD); n_err++;
            end
            @(negedge clk);
        end
        idle(); #1;
        n_vec++; if (outs_a() !== O_NONE) begin $display("FAIL timeout_after got %b want %b", outs_a(), O_NONE); n_err++; end
        @(negedge clk);
        n_vec++; if (ifa.stall_cnt !== 32'd8) begin $display("FAIL timeout_stall_cnt got %0d want 8", ifa.stall_cnt); n_err++; end
    endtask

    task automatic test_lu_wait();
        logic [5:0] exp_b [6];
        exp_b = '{O_LU, O_HOLD, O_HOLD, O_LU, O_LU, O_NONE};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            case (i)
                0:       lu_vec();
                1, 2:    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
                3:       drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
                default: idle();
            endcase
            #1;
            n_vec++; if (outs_b() !== exp_b[i]) begin $display("FAIL lu_wait_cycle%0d got %b want %b", i, outs_b(), exp_b[i]); n_err++; end
            @(negedge clk);
        end
        n_vec++; if (ifb.stall_cnt !== 4'd5) begin $display("FAIL lu_wait_stall_cnt got %0d want 5", ifb.stall_cnt); n_err++; end
    endtask

    task automatic test_reset_sat();
        do_reset();
        lu_vec();
        @(negedge clk);
        // u_b is now mid load-use stall; hazard inputs stay asserted
        #1; rst_n = 1'b0; #1;
        n_vec++; if (outs_b() !== O_NONE) begin $display("FAIL async_rst_outs got %b want %b", outs_b(), O_NONE); n_err++; end
        n_vec++; if (ifb.stall_cnt !== 4'd0) begin $display("FAIL async_rst_cnt got %0d want 0", ifb.stall_cnt); n_err++; end
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        n_vec++; if (ifb.stall_cnt !== 4'hF) begin $display("FAIL sat_stall_cnt got %0d want 15", ifb.stall_cnt); n_err++; end
        ifa.perf_clr = 1'b1;
        @(negedge clk);
        n_vec++; if (ifb.stall_cnt !== 4'd0) begin $display("FAIL clr_stall_cnt got %0d want 0", ifb.stall_cnt); n_err++; end
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0); #1;
        n_vec++; if (outs_b() !== O_NONE) begin $display("FAIL sat_release got %b want %b", outs_b(), O_NONE); n_err++; end
        @(negedge clk);
        idle();
    endtask

    initial begin
        test_reset();
        test_lu_single();
        test_lu_multi();
        test_branch_lu();
        test_mem_wait();
        test_wait_branch();
        test_timeout();
        test_lu_wait();
        test_reset_sat();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
